// File: rtl/serial_full_adder.sv
// ============================================================================
// Module      : serial_full_adder
// Description : Bit-serial WIDTH-bit adder (sum = a + b + cin). One 1-bit
//               full-adder cell, a carry flip-flop and a bit counter process
//               one bit per clock, LSB first, behind a start/ready/valid
//               handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_full_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra counter bit keeps the counter from wrapping before WIDTH-1.
    localparam int                c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;        // operand A, shifted right each RUN cycle
    logic [WIDTH-1:0]   b_q, b_d;        // operand B, shifted right each RUN cycle
    logic               carry_q, carry_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   psum_q, psum_d;  // partial sum, filled from the MSB end
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    // The single full-adder cell always works on bit 0 of the shifted operands.
    logic               w_s;
    logic               w_c;
    logic [WIDTH:0]     w_psum_ext;

    assign w_s        = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_c        = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    // Shifting the new bit in at the top: after WIDTH steps bit 0 holds the LSB.
    // The extra bit makes the slice legal for WIDTH=1 as well.
    assign w_psum_ext = {w_s, psum_q};

    // State register and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = w_c;
                psum_d  = w_psum_ext[WIDTH:1];
                cnt_d   = cnt_q + c_CNT_W'(1);
                // Result registers change only here, so they never show partials.
                if (cnt_q == c_LAST) begin
                    sum_d   = w_psum_ext[WIDTH:1];
                    cout_d  = w_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready = (state_q == S_IDLE);
    assign valid = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

`default_nettype wire
